// File: rtl/hit_judge.sv
// hit_judge: judges key presses against the lit mole and keeps a registered
// score and life count. It emits one-cycle hit/miss events and a sticky
// out-of-lives flag. Everything runs in the single clk domain.
module hit_judge #(
  parameter int MAX_SCORE          = 63,
  parameter int NUM_KEYS           = 9,
  parameter int TIMEOUT_COSTS_LIFE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       enable,
  input  logic       use_lives,
  input  logic [3:0] total_lives,
  input  logic       light_new,
  input  logic       light_off,
  input  logic [3:0] light_pos,
  input  logic       key_down,
  input  logic [3:0] key,
  output logic [5:0] score,
  output logic [3:0] lives_left,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       out_of_lives
);

  localparam logic [4:0] NUM_KEYS_W = 5'(NUM_KEYS);
  localparam logic [5:0] MAX_SCORE_W = 6'(MAX_SCORE);
  localparam logic       TIMEOUT_COST = (TIMEOUT_COSTS_LIFE != 0);

  typedef enum logic [1:0] {IDLE, ARMED, HIT} state_t;

  state_t     state_reg, state_next;
  logic [3:0] target_reg, target_next;
  logic [5:0] score_reg, score_next;
  logic [3:0] lives_reg, lives_next;
  logic       hit_reg, hit_next;
  logic       miss_reg, miss_next;
  logic       ool_reg, ool_next;
  logic       key_down_q;

  logic press;
  logic new_valid;
  logic hit_ev;
  logic wrong_ev;
  logic timeout_ev;
  logic charge;
  logic miss_ev;

  // A press is the rising edge of key_down on a legal key while playing.
  assign press     = key_down & ~key_down_q & enable & ({1'b0, key} < NUM_KEYS_W);
  // A light at an illegal position is treated as if it never happened.
  assign new_valid = light_new & ({1'b0, light_pos} < NUM_KEYS_W);

  // Events are judged against the window and target as they stand this cycle.
  assign hit_ev     = press & (state_reg == ARMED) & (key == target_reg);
  assign wrong_ev   = press & ((state_reg == IDLE) |
                               ((state_reg == ARMED) & (key != target_reg)));
  assign timeout_ev = enable & (state_reg == ARMED) & (new_valid | light_off) & ~hit_ev;
  // A wrong press and a timeout in the same cycle still cost a single life.
  assign charge     = use_lives & (wrong_ev | (timeout_ev & TIMEOUT_COST));
  assign miss_ev    = wrong_ev | (timeout_ev & TIMEOUT_COST & use_lives);

  // Next-state, scoring and life arithmetic; start overrides every event.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    score_next  = score_reg;
    lives_next  = lives_reg;
    ool_next    = ool_reg;
    hit_next    = 1'b0;
    miss_next   = 1'b0;
    if (start) begin
      state_next = IDLE;
      score_next = 6'd0;
      lives_next = total_lives;
      ool_next   = 1'b0;
    end else begin
      if (hit_ev) begin
        hit_next = 1'b1;
        if (score_reg != MAX_SCORE_W) begin
          score_next = score_reg + 6'd1;
        end
      end
      if (miss_ev) begin
        miss_next = 1'b1;
      end
      if (charge && (lives_reg != 4'd0)) begin
        lives_next = lives_reg - 4'd1;
        if (lives_reg == 4'd1) begin
          ool_next = 1'b1;
        end
      end
      if (!enable) begin
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (new_valid) begin
              state_next  = ARMED;
              target_next = light_pos;
            end
          end
          ARMED: begin
            if (new_valid) begin
              state_next  = ARMED;
              target_next = light_pos;
            end else if (light_off) begin
              state_next = IDLE;
            end else if (hit_ev) begin
              state_next = HIT;
            end
          end
          HIT: begin
            if (new_valid) begin
              state_next  = ARMED;
              target_next = light_pos;
            end else if (light_off) begin
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      target_reg <= 4'd0;
      score_reg  <= 6'd0;
      lives_reg  <= 4'd0;
      hit_reg    <= 1'b0;
      miss_reg   <= 1'b0;
      ool_reg    <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      score_reg  <= score_next;
      lives_reg  <= lives_next;
      hit_reg    <= hit_next;
      miss_reg   <= miss_next;
      ool_reg    <= ool_next;
      key_down_q <= key_down;
    end
  end

  assign score        = score_reg;
  assign lives_left   = lives_reg;
  assign hit_pulse    = hit_reg;
  assign miss_pulse   = miss_reg;
  assign out_of_lives = ool_reg;

endmodule

// File: tb/tb_hit_judge.sv
// Testbench for hit_judge. Each cycle's expected outputs are pushed to a
// scoreboard queue when the inputs are driven. They are popped and compared
// one clock later, and directed checks cover the key scenarios.
module tb_hit_judge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       use_lives = 1'b0;
  logic [3:0] total_lives = 4'd0;
  logic       light_new = 1'b0;
  logic       light_off = 1'b0;
  logic [3:0] light_pos = 4'd0;
  logic       key_down = 1'b0;
  logic [3:0] key = 4'd0;
  logic [5:0] score;
  logic [3:0] lives_left;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       out_of_lives;

  hit_judge dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable),
    .use_lives(use_lives), .total_lives(total_lives),
    .light_new(light_new), .light_off(light_off), .light_pos(light_pos),
    .key_down(key_down), .key(key), .score(score), .lives_left(lives_left),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .out_of_lives(out_of_lives)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] score;
    logic [3:0] lives;
    logic       hit;
    logic       miss;
    logic       ool;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;
  int hit_seen = 0;
  int miss_seen = 0;

  // Reference model of the game rules (0 idle, 1 armed, 2 hit).
  int         m_state = 0;
  logic [3:0] m_target = 4'd0;
  logic       m_kq = 1'b0;
  exp_t       m_out = '0;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, obs, exp_v, txn);
    end
  endtask

  function automatic exp_t model_step();
    exp_t n;
    logic press, lnv, hit, wrong, tmo, chg;
    n = m_out;
    n.hit = 1'b0;
    n.miss = 1'b0;
    press = key_down && !m_kq && enable && (key < 4'd9);
    lnv = light_new && (light_pos < 4'd9);
    hit = press && m_state == 1 && key == m_target;
    wrong = press && (m_state == 0 || (m_state == 1 && key != m_target));
    tmo = enable && m_state == 1 && (lnv || light_off) && !hit;
    chg = use_lives && (wrong || tmo);
    if (reset) begin
      n = '0;
      m_state = 0;
      m_target = 4'd0;
      m_kq = 1'b0;
      return n;
    end
    m_kq = key_down;
    if (start) begin
      n.score = 6'd0;
      n.lives = total_lives;
      n.ool = 1'b0;
      m_state = 0;
      return n;
    end
    if (hit) begin
      n.hit = 1'b1;
      if (n.score != 6'd63) n.score = n.score + 6'd1;
    end
    n.miss = wrong || (tmo && use_lives);
    if (chg && n.lives != 4'd0) begin
      if (n.lives == 4'd1) n.ool = 1'b1;
      n.lives = n.lives - 4'd1;
    end
    if (!enable) m_state = 0;
    else if (m_state == 0) begin
      if (lnv) begin m_state = 1; m_target = light_pos; end
    end else begin
      if (lnv) begin m_state = 1; m_target = light_pos; end
      else if (light_off) m_state = 0;
      else if (hit) m_state = 2;
    end
    return n;
  endfunction

  // Drive current inputs for one cycle: push expectation, clock, pop, compare.
  task automatic step();
    exp_t e;
    m_out = model_step();
    sb_q.push_back(m_out);
    @(posedge clk);
    #1;
    txn++;
    e = sb_q.pop_front();
    check_val("score", int'(score), int'(e.score));
    check_val("lives", int'(lives_left), int'(e.lives));
    check_val("hit", int'(hit_pulse), int'(e.hit));
    check_val("miss", int'(miss_pulse), int'(e.miss));
    check_val("ool", int'(out_of_lives), int'(e.ool));
    if (hit_pulse) hit_seen++;
    if (miss_pulse) miss_seen++;
    $display("txn %0d score=%0d lives=%0d hit=%0b miss=%0b ool=%0b",
             txn, score, lives_left, hit_pulse, miss_pulse, out_of_lives);
    light_new = 1'b0;
    light_off = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic new_light(input logic [3:0] p);
    light_new = 1'b1;
    light_pos = p;
    step();
  endtask

  task automatic off_light();
    light_off = 1'b1;
    step();
  endtask

  task automatic tap(input logic [3:0] k);
    key_down = 1'b1;
    key = k;
    step();
    key_down = 1'b0;
    step();
  endtask

  task automatic do_start(input logic [3:0] tl);
    start = 1'b1;
    total_lives = tl;
    step();
  endtask

  initial begin
    int h0, m0;
    // Reset and round start.
    idle(2);
    check_val("rst_score", int'(score), 0);
    check_val("rst_lives", int'(lives_left), 0);
    reset = 1'b0;
    enable = 1'b1;
    do_start(4'd3);
    check_val("start_lives", int'(lives_left), 3);
    check_val("start_score", int'(score), 0);

    // Hit with a long hold, then a re-press in HIT is ignored.
    new_light(4'd4);
    h0 = hit_seen;
    key_down = 1'b1;
    key = 4'd4;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) check_val("hit_latency", int'(hit_pulse), 1);
    end
    key_down = 1'b0;
    step();
    check_val("hold_one_hit", hit_seen - h0, 1);
    m0 = miss_seen;
    tap(4'd4);
    check_val("hit_ignored_score", int'(score), 1);
    check_val("hit_ignored_miss", miss_seen - m0, 0);
    off_light();

    // Lives mode: wrong press, then two timeouts.
    use_lives = 1'b1;
    m0 = miss_seen;
    new_light(4'd5);
    tap(4'd2);
    check_val("lives_after_wrong", int'(lives_left), 2);
    off_light();
    check_val("lives_after_to1", int'(lives_left), 1);
    new_light(4'd3);
    off_light();
    check_val("lives_after_to2", int'(lives_left), 0);
    check_val("ool_set", int'(out_of_lives), 1);
    check_val("three_misses", miss_seen - m0, 3);
    tap(4'd1);
    check_val("lives_floor", int'(lives_left), 0);
    idle(3);
    check_val("ool_held", int'(out_of_lives), 1);
    do_start(4'd2);
    check_val("ool_cleared", int'(out_of_lives), 0);

    // Wrong press coinciding with a timeout costs one life only.
    new_light(4'd6);
    key_down = 1'b1;
    key = 4'd0;
    light_off = 1'b1;
    step();
    key_down = 1'b0;
    check_val("single_decrement", int'(lives_left), 1);
    step();

    // Saturation: climb to 62, then three more hits.
    use_lives = 1'b0;
    do_start(4'd3);
    for (int i = 0; i < 62; i++) begin
      new_light(4'(i % 9));
      tap(4'(i % 9));
      off_light();
    end
    check_val("score_62", int'(score), 62);
    for (int i = 0; i < 3; i++) begin
      new_light(4'd8);
      key_down = 1'b1;
      key = 4'd8;
      step();
      check_val("sat_hit_pulse", int'(hit_pulse), 1);
      check_val("sat_score", int'(score), 63);
      key_down = 1'b0;
      off_light();
    end

    // Press judged against old target while light_new re-arms.
    do_start(4'd3);
    new_light(4'd7);
    key_down = 1'b1;
    key = 4'd7;
    light_new = 1'b1;
    light_pos = 4'd1;
    step();
    key_down = 1'b0;
    check_val("sim_hit_score", int'(score), 1);
    step();
    tap(4'd1);
    check_val("new_target_hit", int'(score), 2);
    off_light();

    // Start with a press in the same cycle discards the press.
    new_light(4'd2);
    key_down = 1'b1;
    key = 4'd2;
    start = 1'b1;
    step();
    key_down = 1'b0;
    check_val("start_press_score", int'(score), 0);
    check_val("start_press_hit", int'(hit_pulse), 0);
    step();

    // Illegal key and presses while disabled are ignored.
    use_lives = 1'b1;
    new_light(4'd3);
    h0 = hit_seen;
    m0 = miss_seen;
    tap(4'd12);
    enable = 1'b0;
    tap(4'd3);
    tap(4'd5);
    check_val("ignored_pulses", (hit_seen - h0) + (miss_seen - m0), 0);
    check_val("ignored_lives", int'(lives_left), 3);
    enable = 1'b1;

    // Reset in the middle of an armed window.
    new_light(4'd4);
    reset = 1'b1;
    step();
    check_val("midrst_lives", int'(lives_left), 0);
    reset = 1'b0;
    do_start(4'd5);

    // Random play checked against the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 59) == 0);
      enable = ($urandom_range(0, 15) != 0);
      use_lives = ($urandom_range(0, 3) != 0);
      total_lives = 4'($urandom_range(1, 9));
      light_new = ($urandom_range(0, 5) == 0);
      light_off = ($urandom_range(0, 7) == 0);
      light_pos = 4'($urandom_range(0, 10));
      key_down = ($urandom_range(0, 2) == 0);
      key = 4'($urandom_range(0, 11));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Sits downstream of light_controller and keypad_controller, upstream of the score/lives displays.
- Judges each key press against the currently lit mole and produces a clean, registered score and life count.
- Emits single-cycle hit/miss events and an out-of-lives flag for the game state machine.
- Replaces combinational/edge-triggered scoring with one synchronous clock domain.

Parameters:
MAX_SCORE, 63, score saturates at this value (6-bit)
NUM_KEYS, 9, key/light codes 0..NUM_KEYS-1 valid; others ignored
TIMEOUT_COSTS_LIFE, 1, 1 = a light that expires un-hit costs a life in lives mode

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse at round start: clear score, load lives
enable  in  1  high during PLAY; when low no events are judged
use_lives  in  1  lives mode active
total_lives  in  4  lives loaded on start (1..9)
light_new  in  1  one-cycle pulse: new light lit at light_pos
light_off  in  1  one-cycle pulse: current light extinguished
light_pos  in  4  position of lit light, valid with light_new
key_down  in  1  level, high while a valid key is held
key  in  4  code of held key, valid while key_down
score  out  6  player hits
lives_left  out  4  remaining lives
hit_pulse  out  1  one cycle per correct hit
miss_pulse  out  1  one cycle per wrong press or lives-costing timeout
out_of_lives  out  1  sticky; set when lives_left reaches 0 in lives mode

Behaviour:
- Reset values: score=0, lives_left=0, hit_pulse=0, miss_pulse=0, out_of_lives=0, state=IDLE, key_down_q=0, target=0.
- Press detection: key_down_q registers key_down.
  - press = key_down & ~key_down_q & enable & (key < NUM_KEYS).
  - Exactly one press per key_down rising edge; holding the key never repeats.
- Window FSM:
  - IDLE: no light. Goes to ARMED on light_new (light_pos captured into target).
  - ARMED: light lit, not yet hit. Goes to HIT on a matching press; to IDLE on light_off; re-arms with the new target on light_new.
  - HIT: light already scored. Goes to IDLE on light_off; to ARMED on light_new.
  - enable low forces IDLE (window discarded, no timeout charged).
- Judging of a press:
  - ARMED and key==target: score+1 (saturate at MAX_SCORE), hit_pulse.
  - ARMED with key!=target, or any press in IDLE: miss_pulse; in lives mode lives_left-1.
  - HIT: press ignored (no score, no miss).
- Timeout: leaving ARMED via light_off or light_new without a hit is a timeout. With TIMEOUT_COSTS_LIFE=1 and use_lives, it raises miss_pulse and decrements lives.
- Latency: a press or timeout judged in cycle N updates score/lives and raises the pulse, all visible in cycle N+1. Pulses are exactly one cycle wide.
- Lives arithmetic:
  - lives_left never decrements below 0.
  - At most one decrement per cycle, even if a wrong press and a timeout coincide; miss_pulse is asserted once.
  - out_of_lives sets the cycle lives_left becomes 0 through a decrement; it stays set until start or reset.
  - With use_lives low, lives_left holds its value and out_of_lives never sets.
- Simultaneous events:
  - A press in the same cycle as light_new/light_off is judged against the pre-update window and target; the window updates afterwards.
  - Press and light_off together in ARMED with a match: counts as a hit, no timeout.
- start: highest priority below reset.
  - score=0, lives_left=total_lives, out_of_lives=0, state=IDLE, pulses 0.
  - Any press or light event in the same cycle is discarded.
- Reset mid-operation restores all reset values on the next clock edge regardless of other inputs.

Test Plan:
- Reset, start with total_lives=3 -> score=0, lives_left=3, out_of_lives=0, no pulses.
- light_new pos=4, then press key=4 held 20 cycles -> score=1, one hit_pulse one cycle after the edge; a second press of key=4 before light_off -> ignored.
- use_lives=1, lives=3: press key=2 with target 5, then let two lights expire un-hit -> lives 2,1,0; three miss_pulses; out_of_lives=1 after the third event and held until start.
- Score preset to 62 by hits, then three more correct hits -> score 63, 63, 63; hit_pulse still fires each time.
- Same-cycle press key=7 matching target 7 with light_new pos=1 -> score+1, new target 1 in ARMED; same-cycle start with a press -> score=0, no pulse.
- Press key=12, and any press while enable=0 -> no pulses, score and lives unchanged; reset asserted mid-ARMED -> all outputs 0 next cycle.
